// File: rtl/costas_acq_ctrl.sv
// Costas loop frequency-acquisition controller: centre-out NCO sweep, per-candidate lock scoring.
// Optional lock monitoring in LOCKED is enabled by defining COSTAS_ACQ_RELOCK_EN.
module costas_acq_ctrl #(
  parameter logic [31:0] FREQ_CENTER   = 32'd143165577,
  parameter logic [31:0] FREQ_STEP     = 32'd1431656,
  parameter int unsigned SWEEP_N       = 8,
  parameter int unsigned SETTLE_CYCLES = 3000,
  parameter int unsigned DWELL_CYCLES  = 30000,
  parameter logic [15:0] LOCK_THRESH   = 16'd12000,
  parameter int unsigned HIT_MIN       = 20000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] lock_metric,
  input  logic        lock_metric_vld,
  output logic [31:0] freq_inc,
  output logic        freq_load,
  output logic        busy,
  output logic        acq_locked,
  output logic        acq_fail,
  output logic [4:0]  cand_idx
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [19:0]   HITS_SAT    = '1;
  localparam logic [19:0]   HIT_MIN_W   = 20'(HIT_MIN);
  localparam logic [4:0]    K_POS_MAX   = 5'(SWEEP_N);
  localparam logic [4:0]    K_LAST      = 5'd0 - K_POS_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [19:0]     r_hits;
  logic [19:0]     w_hits_nxt;
  logic [19:0]     w_hits_inc;
  logic            w_hit;
  logic [4:0]      r_k;
  logic [4:0]      w_k_nxt;
  logic [4:0]      w_k_adv;
  logic [31:0]     w_k_ext;
  logic [31:0]     w_word;

  logic [31:0]     r_freq_inc;
  logic            r_freq_load;
  logic            r_busy;
  logic            r_locked;
  logic            r_fail;

  assign w_hit      = lock_metric_vld && (lock_metric >= LOCK_THRESH);
  assign w_hits_inc = (w_hit && (r_hits != HITS_SAT)) ? r_hits + 20'd1 : r_hits;

  // Centre-out order 0, +1, -1, +2, -2, ...: positive k mirrors, negative k steps outward.
  always_comb begin
    w_k_adv = 5'd1;
    if (r_k == 5'd0) begin
      w_k_adv = 5'd1;
    end else if (!r_k[4]) begin
      w_k_adv = 5'd0 - r_k;
    end else begin
      w_k_adv = (5'd0 - r_k) + 5'd1;
    end
  end

  // Sign-extended index times step, truncated: wraps modulo 2^32 by construction.
  assign w_k_ext = {{27{w_k_nxt[4]}}, w_k_nxt};
  assign w_word  = FREQ_CENTER + (w_k_ext * FREQ_STEP);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hits_nxt  = r_hits;
    w_k_nxt     = r_k;

    case (r_state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = 5'd0;
        end
      end

      S_LOAD: begin
        w_state_nxt = S_SETTLE;
        w_cnt_nxt   = '0;
      end

      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_DWELL;
          w_cnt_nxt   = '0;
          w_hits_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DWELL: begin
        w_hits_nxt = w_hits_inc;
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = S_EVAL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_EVAL: begin
        w_cnt_nxt  = '0;
        w_hits_nxt = '0;
        if (r_hits >= HIT_MIN_W) begin
          w_state_nxt = S_LOCKED;
        end else if (r_k == K_LAST) begin
          w_state_nxt = S_FAIL;
        end else begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = w_k_adv;
        end
      end

      S_LOCKED: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = 5'd0;
          w_cnt_nxt   = '0;
          w_hits_nxt  = '0;
        end else begin
`ifdef COSTAS_ACQ_RELOCK_EN
          w_hits_nxt = w_hits_inc;
          if (r_cnt == DWELL_LAST) begin
            w_cnt_nxt  = '0;
            w_hits_nxt = '0;
            if (w_hits_inc < HIT_MIN_W) begin
              w_state_nxt = S_LOAD;
              w_k_nxt     = 5'd0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`else
          w_cnt_nxt  = '0;
          w_hits_nxt = '0;
`endif
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_hits_nxt  = '0;
      w_k_nxt     = r_k;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt  <= '0;
      r_hits <= '0;
      r_k    <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hits <= w_hits_nxt;
      r_k    <= w_k_nxt;
    end
  end

  // Outputs are registered from the next state so each flag is aligned with its state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_freq_inc  <= FREQ_CENTER;
      r_freq_load <= 1'b0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_freq_load <= (w_state_nxt == S_LOAD);
      if (w_state_nxt == S_LOAD) begin
        r_freq_inc <= w_word;
      end
      r_busy   <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_LOCKED) ||
                    (w_state_nxt == S_FAIL));
      r_locked <= (w_state_nxt == S_LOCKED);
      r_fail   <= (w_state_nxt == S_FAIL);
    end
  end

  assign freq_inc   = r_freq_inc;
  assign freq_load  = r_freq_load;
  assign busy       = r_busy;
  assign acq_locked = r_locked;
  assign acq_fail   = r_fail;
  assign cand_idx   = r_k;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Scoreboard bench for costas_acq_ctrl: expected NCO loads are queued by the stimulus and popped by a monitor.
module tb_costas_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, abort_a = 1'b0, vld_a = 1'b0;
  logic [15:0] metric_a;
  logic [15:0] m_const_a = 16'd0;
  int          mode_a = 0;
  logic [31:0] inc_a;
  logic        load_a, busy_a, locked_a, fail_a;
  logic [4:0]  idx_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [31:0] inc_b;
  logic        load_b, busy_b, locked_b, fail_b;
  logic [4:0]  idx_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  idx;
    int          gap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   ncyc = 0, last_a = 0, last_b = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (mode_a == 1) metric_a = (inc_a == 32'd900) ? 16'd20000 : 16'd0;
    else             metric_a = m_const_a;
  end

  costas_acq_ctrl #(
    .FREQ_CENTER(32'd1000), .FREQ_STEP(32'd100), .SWEEP_N(2),
    .SETTLE_CYCLES(4), .DWELL_CYCLES(16), .LOCK_THRESH(16'd12000), .HIT_MIN(8)
  ) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .abort(abort_a),
    .lock_metric(metric_a), .lock_metric_vld(vld_a),
    .freq_inc(inc_a), .freq_load(load_a), .busy(busy_a),
    .acq_locked(locked_a), .acq_fail(fail_a), .cand_idx(idx_a)
  );

  costas_acq_ctrl #(
    .FREQ_CENTER(32'hFFFFFFC0), .FREQ_STEP(32'd100), .SWEEP_N(2),
    .SETTLE_CYCLES(4), .DWELL_CYCLES(16), .LOCK_THRESH(16'd12000), .HIT_MIN(8)
  ) u_wrap (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .abort(abort_b),
    .lock_metric(16'd0), .lock_metric_vld(1'b1),
    .freq_inc(inc_b), .freq_load(load_b), .busy(busy_b),
    .acq_locked(locked_b), .acq_fail(fail_b), .cand_idx(idx_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] w, input logic [4:0] k, input int gap);
    exp_t e;
    e.word = w; e.idx = k; e.gap = gap;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] w, input logic [4:0] k, input int gap);
    exp_t e;
    e.word = w; e.idx = k; e.gap = gap;
    qb.push_back(e);
  endtask

  // Monitor: every freq_load must match the head of the expected queue.
  always @(negedge clk) begin
    ncyc++;
    if (load_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_load: got freq_inc=%0h expected no load", inc_a);
      end else begin
        ea = qa.pop_front();
        check("a_freq_inc", inc_a, ea.word);
        check("a_cand_idx", {27'd0, idx_a}, {27'd0, ea.idx});
        if (ea.gap != 0) check("a_load_gap", 32'(ncyc - last_a), 32'(ea.gap));
      end
      last_a = ncyc;
    end
    if (load_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_load: got freq_inc=%0h expected no load", inc_b);
      end else begin
        eb = qb.pop_front();
        check("b_freq_inc", inc_b, eb.word);
        check("b_cand_idx", {27'd0, idx_b}, {27'd0, eb.idx});
        if (eb.gap != 0) check("b_load_gap", 32'(ncyc - last_b), 32'(eb.gap));
      end
      last_b = ncyc;
    end
  end

  function automatic logic flag_a(input int which);
    case (which)
      0:       return locked_a;
      1:       return fail_a;
      default: return !locked_a;
    endcase
  endfunction

  task automatic wait_flag(input int which, input int limit, output int cyc);
    cyc = 0;
    while (!flag_a(which) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  int cyc;
  int stayed;

  initial begin
    // 1: reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_freq_inc", inc_a, 32'd1000);
    check("rst_flags", {28'd0, load_a, busy_a, locked_a, fail_a}, 32'd0);
    check("rst_cand_idx", {27'd0, idx_a}, 32'd0);

    // 2: immediate lock at centre
    m_const_a = 16'd20000; vld_a = 1'b1;
    push_a(32'd1000, 5'd0, 0);
    pulse_start_a();
    check("t2_busy", {31'd0, busy_a}, 32'd1);
    wait_flag(0, 100, cyc);
    check("t2_lock_latency", 32'(cyc + 1), 32'd23);
    check("t2_locked", {31'd0, locked_a}, 32'd1);
    check("t2_busy_low", {31'd0, busy_a}, 32'd0);
    check("t2_cand_idx", {27'd0, idx_a}, 32'd0);

    // 3: lock only at 900
    mode_a = 1;
    push_a(32'd1000, 5'd0, 0);
    push_a(32'd1100, 5'd1, 22);
    push_a(32'd900, 5'h1F, 22);
    pulse_start_a();
    wait_flag(0, 200, cyc);
    check("t3_lock_latency", 32'(cyc + 1), 32'd67);
    check("t3_freq_inc", inc_a, 32'd900);
    check("t3_cand_idx", {27'd0, idx_a}, 32'h1F);

    // 4: exhaust the sweep
    mode_a = 0; m_const_a = 16'd0;
    push_a(32'd1000, 5'd0, 0);
    push_a(32'd1100, 5'd1, 22);
    push_a(32'd900, 5'h1F, 22);
    push_a(32'd1200, 5'd2, 22);
    push_a(32'd800, 5'h1E, 22);
    pulse_start_a();
    wait_flag(1, 300, cyc);
    check("t4_fail_latency", 32'(cyc + 1), 32'd111);
    check("t4_fail", {31'd0, fail_a}, 32'd1);
    check("t4_busy", {31'd0, busy_a}, 32'd0);
    check("t4_locked", {31'd0, locked_a}, 32'd0);
    check("t4_freq_inc", inc_a, 32'd800);

    // 5: wrap and abort-over-start in DWELL
    push_b(32'hFFFFFFC0, 5'd0, 0);
    push_b(32'h00000024, 5'd1, 22);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_busy_before_abort", {31'd0, busy_b}, 32'd1);
    abort_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    abort_b = 1'b0; start_b = 1'b0;
    check("t5_abort_flags", {28'd0, load_b, busy_b, locked_b, fail_b}, 32'd0);
    check("t5_freq_inc_kept", inc_b, 32'h00000024);
    repeat (30) @(negedge clk);
    check("t5_idle_busy", {31'd0, busy_b}, 32'd0);

    // 6: behaviour after lock when the metric disappears
    m_const_a = 16'd20000;
    push_a(32'd1000, 5'd0, 0);
    pulse_start_a();
    wait_flag(0, 100, cyc);
    check("t6_lock_latency", 32'(cyc + 1), 32'd23);
    m_const_a = 16'd0;
`ifdef COSTAS_ACQ_RELOCK_EN
    push_a(32'd1000, 5'd0, 0);
    wait_flag(2, 40, cyc);
    check("t6_unlock_within_17", {31'd0, (cyc <= 17)}, 32'd1);
    check("t6_busy_relock", {31'd0, busy_a}, 32'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
`else
    stayed = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (locked_a && !busy_a) stayed++;
    end
    check("t6_hold_locked", 32'(stayed), 32'd200);
`endif

    // async reset mid-sweep, no load on release
    push_a(32'd1000, 5'd0, 0);
    push_a(32'd1100, 5'd1, 22);
    pulse_start_a();
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_freq_inc", inc_a, 32'd1000);
    check("rst_async_flags", {28'd0, load_a, busy_a, locked_a, fail_a}, 32'd0);
    check("rst_async_idx", {27'd0, idx_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
